// File: rtl/move_detector.sv
// Chessboard move detector: debounces raw 64-square occupancy frames and tracks
// lift/place sequences against a reference board to report quiet moves and captures.
module move_detector #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] chessLayout,
  input  logic        scan_done,
  input  logic        resync,
  input  logic        move_ready,
  output logic        move_valid,
  output logic [5:0]  from_sq,
  output logic [5:0]  to_sq,
  output logic        capture,
  output logic        error,
  output logic        busy,
  output logic [63:0] board_state
);

  localparam logic [63:0] INIT_LAYOUT = 64'hFFFF_0000_0000_FFFF;
  localparam logic [3:0]  CNT_MAX     = 4'(DEBOUNCE_FRAMES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LIFT1  = 3'd1;
  localparam logic [2:0] ST_LIFT2  = 3'd2;
  localparam logic [2:0] ST_REPORT = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  function automatic logic is_onehot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

  function automatic logic [5:0] bit_index(input logic [63:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) begin
        idx = 6'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [63:0] sq_mask(input logic [5:0] sq);
    return 64'd1 << sq;
  endfunction

  // Debounce state
  logic [63:0] last_frame_q, last_frame_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] stable_q, stable_d;
  logic        strobe_q, strobe_d;

  // Move tracking state
  logic [2:0]  state_q, state_d;
  logic [63:0] ref_q, ref_d;
  logic [63:0] pending_q, pending_d;
  logic [5:0]  lift_a_q, lift_a_d;
  logic [5:0]  lift_b_q, lift_b_d;

  // Output registers
  logic        mv_q, mv_d;
  logic [5:0]  from_q, from_d;
  logic [5:0]  to_q, to_d;
  logic        cap_q, cap_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic        frame_match_s;
  logic        eval_s;
  logic [63:0] lifted_s;
  logic [63:0] added_s;
  logic [63:0] bit_a_s;
  logic [63:0] bit_b_s;
  logic [63:0] lifted_rest_s;

  // Frame debounce: count repeats of the same frame, strobe once per new stable layout
  always_comb begin
    frame_match_s = (chessLayout == last_frame_q);
    last_frame_d  = last_frame_q;
    cnt_d         = cnt_q;
    stable_d      = stable_q;
    strobe_d      = 1'b0;
    if (scan_done) begin
      if (frame_match_s) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if ((cnt_d == CNT_MAX) && (chessLayout != stable_q)) begin
          stable_d = chessLayout;
          strobe_d = 1'b1;
        end else begin
          strobe_d = 1'b0;
        end
      end else begin
        cnt_d        = 4'd0;
        last_frame_d = chessLayout;
      end
    end else begin
      strobe_d = 1'b0;
    end
  end

  // Move FSM: compare stable layout against reference on each accepted strobe
  always_comb begin
    eval_s        = strobe_q & ~resync;
    lifted_s      = ref_q & ~stable_q;
    added_s       = stable_q & ~ref_q;
    bit_a_s       = sq_mask(lift_a_q);
    bit_b_s       = sq_mask(lift_b_q);
    lifted_rest_s = lifted_s & ~bit_a_s;

    state_d   = state_q;
    ref_d     = ref_q;
    pending_d = pending_q;
    lift_a_d  = lift_a_q;
    lift_b_d  = lift_b_q;
    from_d    = from_q;
    to_d      = to_q;
    cap_d     = cap_q;

    case (state_q)
      ST_IDLE: begin
        if (eval_s) begin
          if (stable_q == ref_q) begin
            state_d = ST_IDLE;
          end else if ((added_s == 64'd0) && is_onehot(lifted_s)) begin
            lift_a_d = bit_index(lifted_s);
            state_d  = ST_LIFT1;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LIFT1: begin
        if (eval_s) begin
          if (stable_q == ref_q) begin
            state_d = ST_IDLE;
          end else if ((lifted_s == bit_a_s) && is_onehot(added_s)) begin
            from_d    = lift_a_q;
            to_d      = bit_index(added_s);
            cap_d     = 1'b0;
            pending_d = stable_q;
            state_d   = ST_REPORT;
          end else if ((added_s == 64'd0) && ((lifted_s & bit_a_s) != 64'd0)
                       && is_onehot(lifted_rest_s)) begin
            lift_b_d = bit_index(lifted_rest_s);
            state_d  = ST_LIFT2;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_LIFT1;
        end
      end
      ST_LIFT2: begin
        if (eval_s) begin
          if ((added_s == 64'd0) && (lifted_s == bit_a_s)) begin
            from_d    = lift_a_q;
            to_d      = lift_b_q;
            cap_d     = 1'b1;
            pending_d = stable_q;
            state_d   = ST_REPORT;
          end else if ((added_s == 64'd0) && (lifted_s == bit_b_s)) begin
            from_d    = lift_b_q;
            to_d      = lift_a_q;
            cap_d     = 1'b1;
            pending_d = stable_q;
            state_d   = ST_REPORT;
          end else if (stable_q == ref_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_LIFT2;
        end
      end
      ST_REPORT: begin
        if (mv_q && move_ready) begin
          ref_d   = pending_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REPORT;
        end
      end
      ST_ERROR: begin
        if (eval_s && (stable_q == ref_q)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Resync overrides everything, including a simultaneous handshake
    if (resync) begin
      ref_d   = stable_q;
      state_d = ST_IDLE;
    end else begin
      ref_d = ref_d;
    end

    mv_d   = (state_d == ST_REPORT);
    err_d  = (state_d == ST_ERROR);
    busy_d = (state_d != ST_IDLE);
    if (!mv_d) begin
      from_d = 6'd0;
      to_d   = 6'd0;
      cap_d  = 1'b0;
    end else begin
      cap_d = cap_d;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_frame_q <= INIT_LAYOUT;
      cnt_q        <= 4'd0;
      stable_q     <= INIT_LAYOUT;
      strobe_q     <= 1'b0;
      state_q      <= ST_IDLE;
      ref_q        <= INIT_LAYOUT;
      pending_q    <= INIT_LAYOUT;
      lift_a_q     <= 6'd0;
      lift_b_q     <= 6'd0;
      mv_q         <= 1'b0;
      from_q       <= 6'd0;
      to_q         <= 6'd0;
      cap_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      last_frame_q <= last_frame_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      strobe_q     <= strobe_d;
      state_q      <= state_d;
      ref_q        <= ref_d;
      pending_q    <= pending_d;
      lift_a_q     <= lift_a_d;
      lift_b_q     <= lift_b_d;
      mv_q         <= mv_d;
      from_q       <= from_d;
      to_q         <= to_d;
      cap_q        <= cap_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign move_valid  = mv_q;
  assign from_sq     = from_q;
  assign to_sq       = to_q;
  assign capture     = cap_q;
  assign error       = err_q;
  assign busy        = busy_q;
  assign board_state = ref_q;

endmodule

// File: tb/tb_move_detector.sv
// Scoreboard bench for move_detector: expected moves are queued as stimulus is
// driven and checked when the detector presents them.
module tb_move_detector;

  localparam logic [63:0] INIT = 64'hFFFF_0000_0000_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] chessLayout;
  logic        scan_done;
  logic        resync;
  logic        move_ready;
  logic        move_valid;
  logic [5:0]  from_sq;
  logic [5:0]  to_sq;
  logic        capture;
  logic        error;
  logic        busy;
  logic [63:0] board_state;

  logic [12:0] exp_q[$];
  logic [12:0] exp_mv;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  move_detector #(.DEBOUNCE_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .chessLayout(chessLayout), .scan_done(scan_done),
    .resync(resync), .move_ready(move_ready), .move_valid(move_valid),
    .from_sq(from_sq), .to_sq(to_sq), .capture(capture), .error(error),
    .busy(busy), .board_state(board_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; scan_done = 1'b0; resync = 1'b0; move_ready = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic send_frames(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      chessLayout = v; scan_done = 1'b1;
      tick;
      scan_done = 1'b0;
      tick;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (move_valid) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  // Pops the next expected move and compares it against the presented move
  task automatic check_presented(input string name);
    bit ok;
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout: move_valid=%0b required 1 within 20 cycles", name, move_valid);
    end else begin
      exp_mv = exp_q.pop_front();
      if ({from_sq, to_sq, capture} !== exp_mv) begin
        failures++;
        $display("FAIL %s_move: got from=%0d to=%0d cap=%0b, required from=%0d to=%0d cap=%0b",
                 name, from_sq, to_sq, capture, exp_mv[12:7], exp_mv[6:1], exp_mv[0]);
      end
    end
  endtask

  task automatic test_reset;
    chessLayout = 64'h0123_4567_89AB_CDEF;
    do_reset;
    checks++;
    if ({move_valid, capture, error, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got mv/cap/err/busy=%b required 0000", {move_valid, capture, error, busy});
    end
    checks++;
    if ({from_sq, to_sq} !== 12'd0) begin
      failures++;
      $display("FAIL reset_squares: got from=%0d to=%0d required 0 0", from_sq, to_sq);
    end
    checks++;
    if (board_state !== INIT) begin
      failures++;
      $display("FAIL reset_board: got %h required %h", board_state, INIT);
    end
  endtask

  task automatic test_stable_initial;
    send_frames(INIT, 3);
    checks++;
    if ({busy, move_valid, error} !== 3'b000 || board_state !== INIT) begin
      failures++;
      $display("FAIL stable_initial: got busy/mv/err=%b board=%h required 000 %h",
               {busy, move_valid, error}, board_state, INIT);
    end
  endtask

  task automatic test_quiet_move;
    logic [63:0] l1, l2;
    l1 = 64'hFFFF_0000_0000_EFFF;
    l2 = 64'hFFFF_0000_1000_EFFF;
    do_reset;
    send_frames(l1, 3);
    checks++;
    if ({busy, move_valid, error} !== 3'b100) begin
      failures++;
      $display("FAIL quiet_lift1: got busy/mv/err=%b required 100", {busy, move_valid, error});
    end
    exp_q.push_back({6'd12, 6'd28, 1'b0});
    send_frames(l2, 3);
    check_presented("quiet");
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (!move_valid || {from_sq, to_sq, capture} !== {6'd12, 6'd28, 1'b0}) begin
        failures++;
        $display("FAIL quiet_hold: cycle %0d got mv=%0b from=%0d to=%0d cap=%0b required 1 12 28 0",
                 i, move_valid, from_sq, to_sq, capture);
      end
    end
    move_ready = 1'b1;
    tick;
    move_ready = 1'b0;
    checks++;
    if ({move_valid, busy} !== 2'b00 || board_state !== l2 || {from_sq, to_sq, capture} !== 13'd0) begin
      failures++;
      $display("FAIL quiet_handshake: got mv=%0b busy=%0b board=%h from=%0d to=%0d required 0 0 %h 0 0",
               move_valid, busy, board_state, from_sq, to_sq, l2);
    end
  endtask

  task automatic test_bounce;
    do_reset;
    send_frames(64'hFFFF_0000_0000_EFFF, 1);
    send_frames(INIT, 1);
    send_frames(64'hFFFF_0000_0000_EFFF, 1);
    send_frames(INIT, 1);
    checks++;
    if ({busy, error} !== 2'b00 || board_state !== INIT) begin
      failures++;
      $display("FAIL bounce: got busy=%0b err=%0b board=%h required 0 0 %h", busy, error, board_state, INIT);
    end
  endtask

  task automatic test_capture;
    logic [63:0] l1, l2;
    l1 = 64'hFFFF_0000_0000_EFFF;
    l2 = 64'hFFFD_0000_0000_EFFF;
    do_reset;
    send_frames(l1, 3);
    send_frames(l2, 3);
    checks++;
    if ({busy, move_valid} !== 2'b10) begin
      failures++;
      $display("FAIL capture_lift2: got busy/mv=%b required 10", {busy, move_valid});
    end
    exp_q.push_back({6'd12, 6'd49, 1'b1});
    send_frames(l1, 3);
    check_presented("capture");
    move_ready = 1'b1;
    tick;
    move_ready = 1'b0;
    checks++;
    if (board_state !== l1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL capture_board: got board=%h busy=%0b required %h 0", board_state, busy, l1);
    end
  endtask

  task automatic test_return;
    do_reset;
    send_frames(64'hFFFF_0000_0000_EFFF, 3);
    send_frames(INIT, 3);
    checks++;
    if ({busy, move_valid, error} !== 3'b000 || board_state !== INIT) begin
      failures++;
      $display("FAIL return: got busy/mv/err=%b board=%h required 000 %h", {busy, move_valid, error}, board_state, INIT);
    end
  endtask

  task automatic test_error;
    do_reset;
    send_frames(64'hFFFF_0001_0000_FFFF, 3);
    checks++;
    if ({error, busy} !== 2'b11) begin
      failures++;
      $display("FAIL error_set: got err/busy=%b required 11", {error, busy});
    end
    send_frames(INIT, 3);
    checks++;
    if ({error, busy} !== 2'b00) begin
      failures++;
      $display("FAIL error_clear: got err/busy=%b required 00", {error, busy});
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    exp_q.push_back({6'd12, 6'd28, 1'b0});
    exp_q.push_back({6'd52, 6'd36, 1'b0});
    send_frames(64'hFFFF_0000_0000_EFFF, 3);
    send_frames(64'hFFFF_0000_1000_EFFF, 3);
    check_presented("b2b_first");
    move_ready = 1'b1;
    tick;
    move_ready = 1'b0;
    send_frames(64'hFFEF_0000_1000_EFFF, 3);
    send_frames(64'hFFEF_0010_1000_EFFF, 3);
    check_presented("b2b_second");
    move_ready = 1'b1;
    tick;
    move_ready = 1'b0;
    checks++;
    if (board_state !== 64'hFFEF_0010_1000_EFFF || move_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_board: got board=%h mv=%0b required ffef001010 00efff 0", board_state, move_valid);
    end
  endtask

  task automatic test_resync_discard;
    do_reset;
    exp_q.push_back({6'd12, 6'd28, 1'b0});
    send_frames(64'hFFFF_0000_0000_EFFF, 3);
    send_frames(64'hFFFF_0000_1000_EFFF, 3);
    check_presented("discard");
    resync = 1'b1; move_ready = 1'b1;
    tick;
    resync = 1'b0; move_ready = 1'b0;
    checks++;
    if ({move_valid, busy} !== 2'b00 || board_state !== 64'hFFFF_0000_1000_EFFF) begin
      failures++;
      $display("FAIL discard_state: got mv=%0b busy=%0b board=%h required 0 0 ffff00001000efff",
               move_valid, busy, board_state);
    end
  endtask

  task automatic test_resync_and_reset;
    logic [63:0] l1;
    l1 = 64'hFFFF_0000_0000_EFFF;
    do_reset;
    send_frames(l1, 3);
    resync = 1'b1;
    tick;
    resync = 1'b0;
    checks++;
    if (busy !== 1'b0 || board_state !== l1) begin
      failures++;
      $display("FAIL resync_lift1: got busy=%0b board=%h required 0 %h", busy, board_state, l1);
    end
    exp_q.push_back({6'd13, 6'd21, 1'b0});
    send_frames(64'hFFFF_0000_0000_CFFF, 3);
    send_frames(64'hFFFF_0000_0020_CFFF, 3);
    check_presented("resync_move");
    reset = 1'b0; move_ready = 1'b1;
    tick;
    checks++;
    if ({move_valid, from_sq, to_sq, capture, error, busy} !== 16'd0 || board_state !== INIT) begin
      failures++;
      $display("FAIL report_reset: got mv=%0b from=%0d to=%0d cap=%0b err=%0b busy=%0b board=%h required all 0 board %h",
               move_valid, from_sq, to_sq, capture, error, busy, board_state, INIT);
    end
    reset = 1'b1; move_ready = 1'b0;
    tick;
    checks++;
    if (move_valid !== 1'b0 || board_state !== INIT) begin
      failures++;
      $display("FAIL report_reset_after: got mv=%0b board=%h required 0 %h", move_valid, board_state, INIT);
    end
  endtask

  initial begin
    reset = 1'b0; scan_done = 1'b0; resync = 1'b0; move_ready = 1'b0;
    chessLayout = INIT;
    test_reset;
    test_stable_initial;
    test_quiet_move;
    test_bounce;
    test_capture;
    test_return;
    test_error;
    test_back_to_back;
    test_resync_discard;
    test_resync_and_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_detector.md
MOVE_DETECTOR -- requirements
Module: move_detector

Interface
REQ-001 SHALL have parameter DEBOUNCE_FRAMES, default 3, number of consecutive identical scan frames before a layout is accepted (legal 2..15).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 SHALL have port chessLayout  input  64  raw occupancy from scanner; bit i = square i = row*8+col; 1 = occupied.
REQ-005 SHALL have port scan_done  input  1  one-cycle pulse; chessLayout holds a complete frame this cycle.
REQ-006 SHALL have port resync  input  1  one-cycle pulse; adopt current stable layout as reference board.
REQ-007 SHALL have port move_ready  input  1  consumer accepts move when high with move_valid.
REQ-008 SHALL have port move_valid  output  1  a move is presented on from_sq/to_sq/capture.
REQ-009 SHALL have port from_sq  output  6  origin square index.
REQ-010 SHALL have port to_sq  output  6  destination square index.
REQ-011 SHALL have port capture  output  1  move removed an occupied destination's piece.
REQ-012 SHALL have port error  output  1  board in an unrecognised configuration.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-014 SHALL have port board_state  output  64  current reference board (ref_layout).

Function
REQ-015 Debounce: on scan_done, if chessLayout == last_frame, cnt increments (saturating at DEBOUNCE_FRAMES-1), else cnt <= 0 and last_frame <= chessLayout.
REQ-016 When cnt reaches DEBOUNCE_FRAMES-1 and the matching frame differs from stable_layout, stable_layout <= frame and stable_strobe pulses exactly one cycle later; identical frames never re-strobe.
REQ-017 FSM states IDLE, LIFT1, LIFT2, REPORT, ERROR; transitions evaluated only on stable_strobe cycles except REPORT handshake and resync; S = stable_layout, R = ref_layout.
REQ-018 IDLE: S == R & ~bit(A) for exactly one A -> from <= A, LIFT1; any other difference -> ERROR.
REQ-019 LIFT1: S == R -> IDLE (piece returned, no move); S == (R & ~bit(A)) | bit(B), B != A -> to <= B, capture <= 0, REPORT; S == R & ~bit(A) & ~bit(B) -> second <= B, LIFT2; else ERROR.
REQ-020 LIFT2: S == R & ~bit(A) -> from=A, to=B, capture=1, REPORT; S == R & ~bit(B) -> from=B, to=A, capture=1, REPORT; S == R -> IDLE; else ERROR.
REQ-021 On REPORT entry, pending <= S; move_valid asserts in the cycle after the deciding stable_strobe (latency 1 cycle).
REQ-022 REPORT: move_valid, from_sq, to_sq, capture SHALL hold constant until move_valid & move_ready; on that cycle R <= pending, state <= IDLE, move_valid deasserts next cycle.
REQ-023 Strobes arriving during REPORT are not evaluated; debounce keeps running; IDLE evaluates the next strobe after handshake.
REQ-024 ERROR: error = 1; on stable_strobe with S == R -> IDLE, error clears next cycle.
REQ-025 resync (any state) has highest priority: R <= S, state <= IDLE, move_valid and error cleared next cycle, even if move_ready is simultaneously high (move discarded).
REQ-026 A stable_strobe coincident with resync SHALL be ignored for FSM evaluation.
REQ-027 from_sq/to_sq/capture SHALL read 0 whenever move_valid is low.

Reset
REQ-028 On reset low at a clk edge: state IDLE, ref_layout, stable_layout and last_frame <= 64'hFFFF_0000_0000_FFFF, cnt <= 0, move_valid=0, from_sq=0, to_sq=0, capture=0, error=0, busy=0, stable_strobe=0.
REQ-029 Reset asserted mid-LIFT/REPORT SHALL abort without producing a handshake; pending move lost.

Verification
REQ-030 Reset, then 3 scan_done frames of FFFF00000000FFFF -> no strobe, busy=0, move_valid=0, board_state unchanged.
REQ-031 3 frames FFFF00000000EFFF then 3 frames FFFF00001000EFFF -> move_valid, from_sq=12, to_sq=28, capture=0; hold move_ready=0 for 4 cycles (outputs stable), then ready -> board_state=FFFF00001000EFFF, busy=0.
REQ-032 Bounce: frames EFFF, FFFF, EFFF, FFFF (low 16 bits, rest initial) -> no strobe, state stays IDLE.
REQ-033 Capture: from initial, lift bit 12, lift bit 49, then S = initial & ~bit12 -> from_sq=12, to_sq=49, capture=1.
REQ-034 IDLE, 3 frames with bit 32 added -> error=1, busy=1; 3 initial frames -> error=0, IDLE.
REQ-035 resync pulse in LIFT1 -> IDLE, board_state = lifted layout; reset low during REPORT -> all outputs at REQ-028 values next cycle.
